card_dealer: RTL and testbench
==============================

Name: card_dealer

Overview:
Parametrised successor to the fixed 54-card card_game dealer.
- Deals unique card indices from a deck of DECK_SIZE cards, without replacement.
- An internal Galois LFSR picks each card; collisions resolve by linear probing.
- Keeps a dealt mask and remaining count, reshuffles on command and accepts a runtime seed.
- Sits between the button debouncer and the game/display logic.

Parameters:
DECK_SIZE, 54, number of cards (2..255)
IDX_W, 6, card index width; must satisfy DECK_SIZE <= 2**IDX_W < 2*DECK_SIZE
LFSR_W, 16, LFSR width (16 only; taps 16,14,13,11, polynomial 0xB400)
SEED, 16'hACE1, LFSR value loaded at reset; must be nonzero

Ports:
clk  in  1  system clock, all logic on rising edge
reset  in  1  synchronous, active-low reset (0 = reset)
draw_card  in  1  draw request level; rising edge detected internally
shuffle  in  1  pulse: clear dealt mask, abort any draw in progress
seed_load  in  1  pulse: load seed_in into LFSR
seed_in  in  16  seed value; 0 is replaced by SEED
card_valid  out  1  one-cycle pulse, card_idx valid
card_idx  out  IDX_W  index of the card just dealt; held until next deal
dealt_cards  out  DECK_SIZE  bit i = 1 when card i has been dealt
cards_left  out  IDX_W+1  number of undealt cards
all_cards_dealt  out  1  high when cards_left == 0
busy  out  1  high in SAMPLE/PROBE
draw_rejected  out  1  one-cycle pulse: draw edge seen while empty or busy

Behaviour:
- Reset (reset == 0 at clk edge) values: card_valid 0, card_idx 0, dealt_cards 0, cards_left DECK_SIZE, all_cards_dealt 0, busy 0, draw_rejected 0, LFSR = SEED, state IDLE, edge-detect register 0.
- LFSR advances every cycle outside reset, including in IDLE.
- Draw edge: draw_card == 1 and the registered previous value == 0.
- FSM states:
  - IDLE: on a draw edge with cards_left > 0, go to SAMPLE. With cards_left == 0, pulse draw_rejected and stay in IDLE.
  - SAMPLE: cand = lfsr[IDX_W-1:0]; if cand >= DECK_SIZE, cand -= DECK_SIZE. Go to PROBE.
  - PROBE: if dealt_cards[cand] == 0, deal cand and go to IDLE. Otherwise cand = (cand == DECK_SIZE-1) ? 0 : cand+1 and stay in PROBE.
  - Deal action (one edge): set dealt bit, decrement cards_left, load card_idx, pulse card_valid.
- Latency, draw edge to card_valid: 3 cycles minimum; worst case DECK_SIZE+2 cycles. Termination is guaranteed because cards_left > 0.
- A draw edge while busy pulses draw_rejected and is not queued.
- shuffle has priority over everything except reset:
  - Next edge: dealt_cards = 0, cards_left = DECK_SIZE, state IDLE, no card_valid.
  - A draw completing in the same cycle is discarded.
  - card_idx keeps its old value.
- seed_load: LFSR <= (seed_in == 0 ? SEED : seed_in). It takes effect on the next edge, overrides the LFSR step that cycle, and leaves the deck untouched.
- all_cards_dealt is registered and rises in the same cycle as the card_valid of the last card.
- Holding draw_card high produces a single draw.
- Simultaneous shuffle and draw edge in IDLE: shuffle wins and the draw is dropped silently (no draw_rejected).

Optional Feature:
Macro SUIT_RANK_EN.
- Defined: adds outputs card_suit[1:0], card_rank[3:0] and card_joker, registered alongside card_idx.
  - idx < 52: suit = idx/13, rank = idx%13 + 1, joker = 0.
  - idx >= 52: suit = 0, rank = 0, joker = 1.
  - All three reset to 0.
- Undefined: these ports and their logic are absent.

Test Plan:
- Reset with SEED=16'hACE1, then 54 separate draw edges -> 54 card_valid pulses, all card_idx distinct and < 54, dealt_cards = all ones, cards_left 0, all_cards_dealt 1.
- 55th draw edge -> draw_rejected pulse, no card_valid, state unchanged.
- Deal 10 cards, pulse shuffle -> next cycle dealt_cards 0, cards_left 54, all_cards_dealt 0.
- seed_load with seed_in=16'h1234, reset-free replay of the same draw timing twice -> identical card_idx sequences; seed_in=0 reproduces the SEED sequence.
- Draw edge asserted again during PROBE, and draw_card held high for 50 cycles -> exactly one card_valid, one draw_rejected.
- DECK_SIZE=5, IDX_W=3 -> all 5 cards dealt exactly once, each card_valid within 7 cycles of its draw edge; with SUIT_RANK_EN and idx 53 -> card_joker 1.

Source files
------------

// File: rtl/card_dealer.sv
// -----------------------------------------------------------------------------
// card_dealer
//
// Deals unique card indices from a deck of DECK_SIZE cards without
// replacement. A free-running 16-bit Galois LFSR proposes a candidate card.
// If that card is already dealt, the next card is tried, wrapping around the
// deck, until a free card is found. The block keeps a dealt mask and a count
// of remaining cards. It reshuffles on command and accepts a runtime seed.
//
// Optional build macro: SUIT_RANK_EN
//   When defined, card_suit/card_rank/card_joker are added. They are
//   registered alongside card_idx.
//
// Ports:
//   clk              system clock, rising edge
//   reset            synchronous, active-low reset
//   draw_card        draw request level (rising edge detected internally)
//   shuffle          pulse: clear dealt mask, abort any draw in progress
//   seed_load        pulse: load seed_in into the LFSR (0 selects SEED)
//   seed_in          runtime seed value
//   card_valid       one-cycle pulse, card_idx holds a freshly dealt card
//   card_idx         index of the last dealt card (held)
//   dealt_cards      bit i set when card i has been dealt
//   cards_left       number of undealt cards
//   all_cards_dealt  high when cards_left == 0
//   busy             high while a draw is being resolved
//   draw_rejected    one-cycle pulse: draw edge seen while empty or busy
//   card_suit/card_rank/card_joker (SUIT_RANK_EN only) decoded card fields
// -----------------------------------------------------------------------------
module card_dealer #(
    parameter int                 DECK_SIZE = 54,
    parameter int                 IDX_W     = 6,
    parameter int                 LFSR_W    = 16,
    parameter logic [LFSR_W-1:0]  SEED      = 16'hACE1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  draw_card,
    input  logic                  shuffle,
    input  logic                  seed_load,
    input  logic [LFSR_W-1:0]     seed_in,
    output logic                  card_valid,
    output logic [IDX_W-1:0]      card_idx,
    output logic [DECK_SIZE-1:0]  dealt_cards,
    output logic [IDX_W:0]        cards_left,
    output logic                  all_cards_dealt,
    output logic                  busy,
    output logic                  draw_rejected
`ifdef SUIT_RANK_EN
    ,
    output logic [1:0]            card_suit,
    output logic [3:0]            card_rank,
    output logic                  card_joker
`endif
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SAMPLE = 2'd1,
        PROBE  = 2'd2
    } state_t;

    // Taps 16,14,13,11 for a right-shifting Galois LFSR.
    localparam logic [LFSR_W-1:0] POLY   = 16'hB400;
    localparam logic [IDX_W:0]    DECK_N = (IDX_W+1)'(DECK_SIZE);
    localparam logic [IDX_W-1:0]  LAST   = IDX_W'(DECK_SIZE - 1);

    state_t                 state, state_nxt;
    logic [LFSR_W-1:0]      lfsr, lfsr_nxt;
    logic [IDX_W-1:0]       cand, cand_nxt, cand_raw;
    logic                   draw_prev, draw_edge;
    logic [DECK_SIZE-1:0]   dealt_nxt;
    logic [IDX_W:0]         left_nxt;
    logic [IDX_W-1:0]       idx_nxt;
    logic                   valid_nxt, rej_nxt, all_nxt;

    assign draw_edge = draw_card & ~draw_prev;
    assign cand_raw  = lfsr[IDX_W-1:0];
    assign busy      = (state != IDLE);

`ifdef SUIT_RANK_EN
    logic [1:0] suit_nxt;
    logic [3:0] rank_nxt;
    logic       joker_nxt;

    // Standard 52-card layout: 13 ranks per suit. Indices 52 and up are jokers.
    function automatic logic [6:0] decode(input logic [IDX_W-1:0] idx);
        int v;
        v = int'(idx);
        if (v < 52)
            return {2'(v / 13), 4'((v % 13) + 1), 1'b0};
        else
            return 7'b0000001;
    endfunction
`endif

    // NOTE: every signal gets a default at the top of this block, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        state_nxt = state;
        cand_nxt  = cand;
        dealt_nxt = dealt_cards;
        left_nxt  = cards_left;
        idx_nxt   = card_idx;
        valid_nxt = 1'b0;
        rej_nxt   = 1'b0;
        // A seed load replaces this cycle's LFSR step.
        if (seed_load)
            lfsr_nxt = (seed_in == '0) ? SEED : seed_in;
        else
            lfsr_nxt = (lfsr >> 1) ^ (lfsr[0] ? POLY : '0);

        case (state)
            IDLE: begin
                if (draw_edge) begin
                    if (cards_left != '0)
                        state_nxt = SAMPLE;
                    else
                        rej_nxt = 1'b1;
                end
            end
            SAMPLE: begin
                rej_nxt = draw_edge;
                // 2**IDX_W < 2*DECK_SIZE, so a single subtraction brings any
                // raw value into range.
                if ({1'b0, cand_raw} >= DECK_N)
                    cand_nxt = cand_raw - DECK_N[IDX_W-1:0];
                else
                    cand_nxt = cand_raw;
                state_nxt = PROBE;
            end
            PROBE: begin
                rej_nxt = draw_edge;
                if (!dealt_cards[cand]) begin
                    dealt_nxt[cand] = 1'b1;
                    left_nxt        = cards_left - 1'b1;
                    idx_nxt         = cand;
                    valid_nxt       = 1'b1;
                    state_nxt       = IDLE;
                end else begin
                    // Probing always terminates, because cards_left > 0
                    // whenever a draw is accepted.
                    cand_nxt = (cand == LAST) ? '0 : cand + 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase

        // Shuffle overrides everything and silently drops any draw in flight.
        // card_idx keeps its last value.
        if (shuffle) begin
            state_nxt = IDLE;
            dealt_nxt = '0;
            left_nxt  = DECK_N;
            idx_nxt   = card_idx;
            valid_nxt = 1'b0;
            rej_nxt   = 1'b0;
        end

        all_nxt = (left_nxt == '0);

`ifdef SUIT_RANK_EN
        if (valid_nxt)
            {suit_nxt, rank_nxt, joker_nxt} = decode(idx_nxt);
        else
            {suit_nxt, rank_nxt, joker_nxt} = {card_suit, card_rank, card_joker};
`endif
    end

    // NOTE: the dealt mask is a plain flop vector, not a memory, so it can be cleared by reset in one cycle like any other register.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state           <= IDLE;
            lfsr            <= SEED;
            cand            <= '0;
            draw_prev       <= 1'b0;
            dealt_cards     <= '0;
            cards_left      <= DECK_N;
            card_idx        <= '0;
            card_valid      <= 1'b0;
            draw_rejected   <= 1'b0;
            all_cards_dealt <= 1'b0;
`ifdef SUIT_RANK_EN
            card_suit       <= '0;
            card_rank       <= '0;
            card_joker      <= 1'b0;
`endif
        end else begin
            // NOTE: non-blocking assignments let every register sample the same pre-edge values.
            state           <= state_nxt;
            lfsr            <= lfsr_nxt;
            cand            <= cand_nxt;
            draw_prev       <= draw_card;
            dealt_cards     <= dealt_nxt;
            cards_left      <= left_nxt;
            card_idx        <= idx_nxt;
            card_valid      <= valid_nxt;
            draw_rejected   <= rej_nxt;
            all_cards_dealt <= all_nxt;
`ifdef SUIT_RANK_EN
            card_suit       <= suit_nxt;
            card_rank       <= rank_nxt;
            card_joker      <= joker_nxt;
`endif
        end
    end

endmodule

// File: tb/tb_card_dealer.sv
// -----------------------------------------------------------------------------
// tb_card_dealer
//
// Self-checking bench for card_dealer. The behavioural model schedules each
// accepted draw. It works out which card will be dealt and on which edge,
// from the LFSR value and the deck contents. A compare process then checks
// every DUT output against the model on every cycle. Directed phases pin the
// model with hand-computed values. A randomised phase follows. A second
// 5-card instance covers the small-deck case.
// -----------------------------------------------------------------------------
module tb_card_dealer;

    localparam int          DECK  = 54;
    localparam int          IDX_W = 6;
    localparam logic [15:0] SEED  = 16'hACE1;

    logic                clk;
    logic                reset;
    logic                draw_card, shuffle, seed_load;
    logic [15:0]         seed_in;
    logic                card_valid, all_cards_dealt, busy, draw_rejected;
    logic [IDX_W-1:0]    card_idx;
    logic [DECK-1:0]     dealt_cards;
    logic [IDX_W:0]      cards_left;

    logic                draw5;
    logic                card_valid5, all5, busy5, rej5;
    logic [2:0]          card_idx5;
    logic [4:0]          dealt5;
    logic [3:0]          left5;

`ifdef SUIT_RANK_EN
    logic [1:0] card_suit, card_suit5;
    logic [3:0] card_rank, card_rank5;
    logic       card_joker, card_joker5;
`endif

    card_dealer #(.DECK_SIZE(DECK), .IDX_W(IDX_W), .LFSR_W(16), .SEED(SEED)) dut (
        .clk(clk), .reset(reset), .draw_card(draw_card), .shuffle(shuffle),
        .seed_load(seed_load), .seed_in(seed_in), .card_valid(card_valid),
        .card_idx(card_idx), .dealt_cards(dealt_cards), .cards_left(cards_left),
        .all_cards_dealt(all_cards_dealt), .busy(busy), .draw_rejected(draw_rejected)
`ifdef SUIT_RANK_EN
        , .card_suit(card_suit), .card_rank(card_rank), .card_joker(card_joker)
`endif
    );

    card_dealer #(.DECK_SIZE(5), .IDX_W(3), .LFSR_W(16), .SEED(SEED)) dut5 (
        .clk(clk), .reset(reset), .draw_card(draw5), .shuffle(1'b0),
        .seed_load(1'b0), .seed_in(16'h0000), .card_valid(card_valid5),
        .card_idx(card_idx5), .dealt_cards(dealt5), .cards_left(left5),
        .all_cards_dealt(all5), .busy(busy5), .draw_rejected(rej5)
`ifdef SUIT_RANK_EN
        , .card_suit(card_suit5), .card_rank(card_rank5), .card_joker(card_joker5)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int n_valid  = 0;
    int n_rej    = 0;
    bit chk_en   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [15:0]     m_lfsr;
    logic            m_prev;
    logic [DECK-1:0] m_dealt;
    int              m_left, m_idx, m_due, m_card;
    logic            m_valid, m_rej, m_all, m_pend;
    int              cyc = 0;

    function automatic logic [15:0] lfsr_step(input logic [15:0] v);
        return (v >> 1) ^ (v[0] ? 16'hB400 : 16'h0000);
    endfunction

    task automatic model_step();
        logic        edge_seen;
        logic [15:0] nl;
        int          c, n;
        if (!reset) begin
            m_lfsr = SEED; m_prev = 0; m_dealt = '0; m_left = DECK; m_idx = 0;
            m_valid = 0; m_rej = 0; m_all = 0; m_pend = 0;
        end else begin
            edge_seen = draw_card && !m_prev;
            nl = seed_load ? ((seed_in == 16'h0) ? SEED : seed_in) : lfsr_step(m_lfsr);
            m_valid = 0;
            m_rej   = 0;
            if (shuffle) begin
                m_dealt = '0; m_left = DECK; m_all = 0; m_pend = 0;
            end else if (m_pend) begin
                if (edge_seen) m_rej = 1;
                if (cyc == m_due) begin
                    m_dealt[m_card] = 1'b1;
                    m_left--;
                    m_idx   = m_card;
                    m_valid = 1;
                    m_pend  = 0;
                    m_all   = (m_left == 0);
                end
            end else if (edge_seen) begin
                if (m_left == 0) begin
                    m_rej = 1;
                end else begin
                    // The candidate comes from the LFSR value held during the
                    // cycle after the draw edge. One edge later the first probe
                    // happens, and each occupied card costs one more edge.
                    c = int'(nl) % (1 << IDX_W);
                    if (c >= DECK) c -= DECK;
                    n = 0;
                    while (m_dealt[c]) begin
                        c = (c + 1) % DECK;
                        n++;
                    end
                    m_pend = 1;
                    m_card = c;
                    m_due  = cyc + 2 + n;
                end
            end
            m_prev = draw_card;
            m_lfsr = nl;
        end
        cyc++;
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    // ---------------- compare process ----------------
    initial forever begin
        @(negedge clk);
        n_valid += int'(card_valid);
        n_rej   += int'(draw_rejected);
        if (chk_en) begin
            check("card_valid", card_valid, m_valid);
            check("card_idx", card_idx, m_idx);
            check("cards_left", cards_left, m_left);
            check("all_cards_dealt", all_cards_dealt, m_all);
            check("busy", busy, m_pend);
            check("draw_rejected", draw_rejected, m_rej);
            check("dealt_cards", dealt_cards, m_dealt);
`ifdef SUIT_RANK_EN
            if (m_valid) begin
                check("card_suit", card_suit, (m_idx < 52) ? m_idx / 13 : 0);
                check("card_rank", card_rank, (m_idx < 52) ? m_idx % 13 + 1 : 0);
                check("card_joker", card_joker, (m_idx >= 52) ? 1 : 0);
            end
`endif
        end
    end

    // One draw: raise the request, wait (bounded) for card_valid, then drop it.
    task automatic do_draw(input bit use5, input int max_wait, output int idx, output int lat);
        bit found;
        found = 0;
        lat   = 0;
        idx   = -1;
        @(negedge clk);
        if (use5) draw5 = 1'b1; else draw_card = 1'b1;
        while (!found && lat < max_wait) begin
            @(negedge clk);
            lat++;
            if (use5 ? card_valid5 : card_valid) begin
                found = 1;
                idx   = use5 ? int'(card_idx5) : int'(card_idx);
            end
        end
        draw5     = 1'b0;
        draw_card = 1'b0;
        check("draw_completed", found, 1);
    endtask

    task automatic replay(input logic [15:0] s, output int seq[8]);
        int lat;
        @(negedge clk);
        shuffle = 1'b1; seed_load = 1'b1; seed_in = s;
        @(negedge clk);
        shuffle = 1'b0; seed_load = 1'b0; seed_in = 16'h0;
        for (int i = 0; i < 8; i++) do_draw(0, DECK + 4, seq[i], lat);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int          idx, lat, v0, r0;
        bit          seen[DECK];
        bit          seen5[5];
        int          seq_a[8], seq_b[8], seq_c[8], seq_d[8];
        logic [63:0] all_ones;

        reset = 1'b0; draw_card = 1'b0; shuffle = 1'b0; seed_load = 1'b0;
        seed_in = 16'h0; draw5 = 1'b0;
        repeat (2) @(negedge clk);
        chk_en = 1;

        // Reset values.
        check("rst_card_valid", card_valid, 0);
        check("rst_card_idx", card_idx, 0);
        check("rst_cards_left", cards_left, 54);
        check("rst_dealt", dealt_cards, 0);
        check("rst_all_dealt", all_cards_dealt, 0);
        check("rst_busy", busy, 0);
        check("rst_rejected", draw_rejected, 0);
`ifdef SUIT_RANK_EN
        check("rst_suit", card_suit, 0);
        check("rst_rank", card_rank, 0);
        check("rst_joker", card_joker, 0);
`endif

        // Deal the whole deck. The first card is computed by hand as follows.
        // The LFSR steps ACE1 -> E270 -> 7138. The low 6 bits are 56, which
        // is reduced to 2.
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < DECK; i++) seen[i] = 0;
        v0 = n_valid;
        for (int i = 0; i < DECK; i++) begin
            do_draw(0, DECK + 4, idx, lat);
            if (i == 0) check("first_card", idx, 2);
            check("card_in_range", (idx >= 0 && idx < DECK), 1);
            if (idx >= 0 && idx < DECK) begin
                check("card_unique", seen[idx], 0);
                seen[idx] = 1;
            end
        end
        all_ones = (64'd1 << DECK) - 64'd1;
        @(negedge clk);
        check("full_dealt_mask", dealt_cards, all_ones);
        check("full_cards_left", cards_left, 0);
        check("full_all_dealt", all_cards_dealt, 1);
        check("full_valid_count", n_valid - v0, 54);

        // 55th draw is rejected.
        v0 = n_valid; r0 = n_rej;
        @(negedge clk); draw_card = 1'b1;
        repeat (6) @(negedge clk);
        draw_card = 1'b0;
        check("empty_reject_count", n_rej - r0, 1);
        check("empty_no_valid", n_valid - v0, 0);
        check("empty_cards_left", cards_left, 0);

        // Shuffle after 10 cards.
        @(negedge clk); shuffle = 1'b1;
        @(negedge clk); shuffle = 1'b0;
        for (int i = 0; i < 10; i++) do_draw(0, DECK + 4, idx, lat);
        check("ten_cards_left", cards_left, 44);
        @(negedge clk); shuffle = 1'b1;
        @(negedge clk); shuffle = 1'b0;
        check("shuf_dealt", dealt_cards, 0);
        check("shuf_cards_left", cards_left, 54);
        check("shuf_all_dealt", all_cards_dealt, 0);

        // Seed replay. With seed 1234 the LFSR steps 1234 -> 091A -> 048D.
        // The low 6 bits give card 13.
        replay(16'h1234, seq_a);
        replay(16'h1234, seq_b);
        check("seed1234_first", seq_a[0], 13);
        for (int i = 0; i < 8; i++) check("seed_replay_match", seq_b[i], seq_a[i]);
        replay(16'h0000, seq_c);
        replay(SEED, seq_d);
        check("seed0_first", seq_c[0], 2);
        for (int i = 0; i < 8; i++) check("seed0_is_default", seq_c[i], seq_d[i]);

        // A second edge while busy, then draw_card held high.
        v0 = n_valid; r0 = n_rej;
        @(negedge clk); draw_card = 1'b1;
        @(negedge clk); draw_card = 1'b0;
        @(negedge clk); draw_card = 1'b1;
        repeat (50) @(negedge clk);
        draw_card = 1'b0;
        repeat (3) @(negedge clk);
        check("held_one_valid", n_valid - v0, 1);
        check("held_one_reject", n_rej - r0, 1);

        // Randomised traffic, checked every cycle by the compare process.
        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            reset     = ($urandom_range(0, 1499) != 0);
            draw_card = $urandom_range(0, 1) != 0;
            shuffle   = ($urandom_range(0, 399) == 0);
            seed_load = ($urandom_range(0, 99) == 0);
            seed_in   = ($urandom_range(0, 3) == 0) ? 16'h0 : 16'($urandom);
        end
        @(negedge clk);
        reset = 1'b1; draw_card = 1'b0; shuffle = 1'b0; seed_load = 1'b0;

        // Small deck: 5 cards with a 3-bit index.
        @(negedge clk); reset = 1'b0;
        @(negedge clk); reset = 1'b1;
        for (int i = 0; i < 5; i++) seen5[i] = 0;
        for (int i = 0; i < 5; i++) begin
            do_draw(1, 9, idx, lat);
            check("d5_latency_le7", (lat >= 3 && lat <= 7), 1);
            check("d5_in_range", (idx >= 0 && idx < 5), 1);
            if (idx >= 0 && idx < 5) begin
                check("d5_unique", seen5[idx], 0);
                seen5[idx] = 1;
            end
        end
        @(negedge clk);
        check("d5_dealt", dealt5, 5'b11111);
        check("d5_left", left5, 0);
        check("d5_all_dealt", all5, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
